// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: state encoding and length normalisation shared by regfile_sequencer
package regfile_seq_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    // A zero or oversize length means "use the whole register file".
    function automatic int norm_len(input int len, input int depth);
        return (len == 0 || len > depth) ? depth : len;
    endfunction
endpackage

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: load-then-drain sequencer for a single-port combinational-read register file
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATATYPE_SIZE = 8,
    parameter int ADDR_WIDTH    = 6
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     start,
    input  logic [ADDR_WIDTH:0]      len,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [DATATYPE_SIZE-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATATYPE_SIZE-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [ADDR_WIDTH-1:0]    rf_addr,
    output logic [DATATYPE_SIZE-1:0] rf_wr_data,
    output logic                     rf_we,
    input  logic [DATATYPE_SIZE-1:0] rf_rd_data,
    output logic                     busy,
    output logic                     done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(DEPTH);
    logic [1:0] state, state_nx;
    logic [ADDR_WIDTH-1:0] idx, idx_nx;
    logic [ADDR_WIDTH:0] len_q, len_nx;
    logic done_nx, last, hs;
    // Wide compare so a full-depth transaction ends at DEPTH-1 without the counter wrapping.
    assign last = {1'b0, idx} == len_q - LEN_ONE;
    assign hs = (state == LOAD && in_valid) || (state == DRAIN && out_ready);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            idx   <= '0;
            len_q <= LEN_MAX;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            len_q <= len_nx;
            done  <= done_nx;
        end
    end
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        len_nx   = len_q;
        done_nx  = 1'b0;
        if (state == IDLE) begin
            if (start && !abort) begin
                state_nx = LOAD;
                idx_nx   = '0;
                len_nx   = (ADDR_WIDTH + 1)'(norm_len(int'(len), DEPTH));
            end
        end else if (abort || state > DRAIN) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end else if (hs) begin
            idx_nx   = last ? '0 : idx + ADDR_WIDTH'(1);
            state_nx = !last ? state : (state == LOAD ? DRAIN : IDLE);
            done_nx  = last && state == DRAIN;
        end
    end
    always_comb begin
        in_ready   = state == LOAD;
        out_valid  = state == DRAIN;
        out_last   = out_valid && last;
        rf_we      = in_ready && in_valid;
        rf_addr    = idx;
        rf_wr_data = in_data;
        out_data   = rf_rd_data;
        busy       = state != IDLE;
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: randomized self-checking bench for regfile_sequencer
module tb_regfile_sequencer;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 64;
    logic CLK, RST_N, start, abort, in_valid, in_ready, out_valid, out_last, out_ready, rf_we, busy, done;
    logic [AW:0] len;
    logic [DW-1:0] in_data, out_data, rf_wr_data, rf_rd_data;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] mem [DEPTH];
    int n_checks = 0, n_pass = 0;
    logic [7:0] stim[$], sent_q[$], got_q[$], wr_data_q[$];
    int wr_addr_q[$], last_q[$];
    int we_err, stall_err, last_err, busy_err, abort_err, done_cnt, done_cyc, last_beat_cyc, last_wr_cyc, first_ov, drain_cycles;
    bit timed_out;

    regfile_sequencer #(.DATATYPE_SIZE(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_we(rf_we), .rf_rd_data(rf_rd_data),
        .busy(busy), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) if (rf_we) mem[rf_addr] <= rf_wr_data;
    assign rf_rd_data = mem[rf_addr];

    function automatic int exp_len(input int l);
        return (l == 0 || l > DEPTH) ? DEPTH : l;
    endfunction

    // vmode: 0 always valid, 1 random, 2 every third cycle; rmode: 0 always ready, 1 pattern 1,0,0, 2 random
    task automatic run_txn(input int len_in, input int vmode, input int rmode, input int abort_beats, input int restart_len);
        int beats, idle;
        bit stalled, was_abort;
        logic [7:0] pd;
        sent_q.delete(); got_q.delete(); wr_data_q.delete(); wr_addr_q.delete(); last_q.delete();
        {we_err, stall_err, last_err, busy_err, abort_err, done_cnt, drain_cycles} = '0;
        done_cyc = -1; last_beat_cyc = -1; last_wr_cyc = -1; first_ov = -1;
        timed_out = 1; beats = 0; idle = 0; stalled = 0; was_abort = 0; pd = '0;
        @(posedge CLK); #1;
        for (int c = 0; c < 3000; c++) begin
            start = (c == 0) || (c == 2 && restart_len >= 0);
            len = (c == 0) ? (AW + 1)'(len_in) : (AW + 1)'(restart_len);
            in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? 1'($urandom_range(1, 0)) : (c % 3 == 2);
            in_data = sent_q.size() < stim.size() ? stim[sent_q.size()] : 8'($urandom);
            out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (drain_cycles % 3 == 0) : 1'($urandom_range(1, 0));
            abort = 1'b0;
            if (abort_beats >= 0 && beats == abort_beats && out_valid) begin
                abort = 1'b1;
                out_ready = 1'b0;
            end
            if (in_ready && in_valid) sent_q.push_back(in_data);
            @(negedge CLK);
            if (rf_we !== (in_ready && in_valid)) we_err++;
            if (rf_we) begin
                wr_addr_q.push_back(int'(rf_addr));
                wr_data_q.push_back(rf_wr_data);
                last_wr_cyc = c;
            end
            if (out_valid && first_ov < 0) first_ov = c;
            if (out_valid && stalled && out_data !== pd) stall_err++;
            if (out_last && !out_valid) last_err++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (out_last) last_q.push_back(got_q.size() - 1);
                last_beat_cyc = c;
                beats++;
            end
            if (out_valid) drain_cycles++;
            stalled = out_valid && !out_ready;
            pd = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (busy) busy_err++;
            end
            if (was_abort && (busy || out_valid || done)) abort_err++;
            was_abort = abort;
            @(posedge CLK); #1;
            idle = busy ? 0 : idle + 1;
            if (idle == 3) begin
                timed_out = 0;
                break;
            end
        end
        {start, abort, in_valid, out_ready} = '0;
    endtask

    task automatic test_reset;
        n_checks++; if ({in_ready, out_valid, out_last, rf_we, busy, done} !== 6'b0) $display("FAIL reset_ctrl got %b exp 000000", {in_ready, out_valid, out_last, rf_we, busy, done}); else n_pass++;
        n_checks++; if (rf_addr !== 6'd0) $display("FAIL reset_addr got %0d exp 0", rf_addr); else n_pass++;
        @(posedge CLK); #1; RST_N = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL reset_idle busy %b in_ready %b exp 0 0", busy, in_ready); else n_pass++;
    endtask

    task automatic test_full;
        int bad;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(8'(i));
        run_txn(0, 0, 0, -1, -1);
        n_checks++; if (timed_out) $display("FAIL full_timeout got 1 exp 0"); else n_pass++;
        bad = (wr_addr_q.size() != 64 || got_q.size() != 64) ? 1000 : 0;
        if (bad == 0) for (int i = 0; i < 64; i++) if (wr_addr_q[i] != i || wr_data_q[i] !== 8'(i) || got_q[i] !== 8'(i)) bad++;
        n_checks++; if (bad != 0) $display("FAIL full_data got %0d writes %0d beats %0d bad exp 64 64 0", wr_addr_q.size(), got_q.size(), bad); else n_pass++;
        n_checks++; if (last_q.size() != 1 || last_q[0] != 63 || last_err != 0) $display("FAIL full_last got %0d marks err %0d exp one at 63", last_q.size(), last_err); else n_pass++;
        n_checks++; if (first_ov != 65) $display("FAIL full_drain_start got %0d exp 65", first_ov); else n_pass++;
        n_checks++; if (done_cnt != 1 || done_cyc != 129 || busy_err != 0) $display("FAIL full_done got cnt %0d cyc %0d busy_err %0d exp 1 129 0", done_cnt, done_cyc, busy_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL full_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure;
        stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run_txn(5, 0, 1, -1, -1);
        n_checks++; if (got_q != stim) $display("FAIL bp_order got %p exp %p", got_q, stim); else n_pass++;
        n_checks++; if (stall_err != 0 || drain_cycles != 13) $display("FAIL bp_stall got err %0d cycles %0d exp 0 13", stall_err, drain_cycles); else n_pass++;
        n_checks++; if (last_q.size() != 1 || last_q[0] != 4) $display("FAIL bp_last got %0d marks exp one at 4", last_q.size()); else n_pass++;
        n_checks++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) $display("FAIL bp_done got cnt %0d cyc %0d exp 1 %0d", done_cnt, done_cyc, last_beat_cyc + 1); else n_pass++;
    endtask

    task automatic test_sparse;
        stim.delete();
        run_txn(3, 2, 0, -1, -1);
        n_checks++; if (wr_addr_q.size() != 3 || we_err != 0) $display("FAIL sparse_writes got %0d err %0d exp 3 0", wr_addr_q.size(), we_err); else n_pass++;
        n_checks++; if (last_wr_cyc != 8 || first_ov != 9) $display("FAIL sparse_drain got wr %0d ov %0d exp 8 9", last_wr_cyc, first_ov); else n_pass++;
        n_checks++; if (got_q != sent_q || got_q.size() != 3) $display("FAIL sparse_data got %p exp %p", got_q, sent_q); else n_pass++;
    endtask

    task automatic test_abort;
        stim.delete();
        run_txn(8, 0, 0, 3, -1);
        n_checks++; if (got_q.size() != 3 || done_cnt != 0) $display("FAIL abort_beats got %0d done %0d exp 3 0", got_q.size(), done_cnt); else n_pass++;
        n_checks++; if (abort_err != 0 || timed_out) $display("FAIL abort_idle got err %0d to %0d exp 0 0", abort_err, timed_out); else n_pass++;
        run_txn(2, 1, 2, -1, -1);
        n_checks++; if (got_q != sent_q || got_q.size() != 2 || wr_addr_q.size() != 2 || wr_addr_q[0] != 0 || wr_addr_q[1] != 1) $display("FAIL abort_after got %p exp %p", got_q, sent_q); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL abort_after_done got %0d exp 1", done_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_load;
        @(posedge CLK); #1; start = 1'b1; len = '0;
        @(posedge CLK); #1; start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(i);
            @(posedge CLK); #1;
        end
        n_checks++; if (rf_addr !== 6'd10 || in_ready !== 1'b1) $display("FAIL midload_addr got %0d ready %b exp 10 1", rf_addr, in_ready); else n_pass++;
        #2 RST_N = 1'b0;
        #1;
        n_checks++; if ({in_ready, out_valid, out_last, rf_we, busy, done} !== 6'b0 || rf_addr !== 6'd0) $display("FAIL async_reset got %b addr %0d exp 000000 0", {in_ready, out_valid, out_last, rf_we, busy, done}, rf_addr); else n_pass++;
        in_valid = 1'b0;
        @(posedge CLK); #1; RST_N = 1'b1;
        stim = '{8'h5A};
        run_txn(1, 0, 0, -1, -1);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) $display("FAIL post_reset_data got %p exp 5a", got_q); else n_pass++;
        n_checks++; if (last_q.size() != 1 || last_q[0] != 0 || done_cnt != 1) $display("FAIL post_reset_last got %0d done %0d exp 1 1", last_q.size(), done_cnt); else n_pass++;
    endtask

    task automatic test_collision;
        @(posedge CLK); #1; start = 1'b1; abort = 1'b1; len = 7'd5;
        @(posedge CLK); #1; start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL collision got busy %b exp 0", busy); else n_pass++;
        stim.delete();
        run_txn(3, 0, 0, -1, 7);
        n_checks++; if (got_q.size() != 3 || wr_addr_q.size() != 3 || got_q != sent_q) $display("FAIL start_busy got %0d beats exp 3", got_q.size()); else n_pass++;
    endtask

    task automatic test_random;
        int l, n, bad;
        for (int t = 0; t < 8; t++) begin
            l = (t == 0) ? 100 : $urandom_range(127, 0);
            n = exp_len(l);
            stim.delete();
            run_txn(l, 1, 2, -1, -1);
            bad = (wr_addr_q.size() != n || got_q.size() != n || sent_q.size() != n) ? 1000 : 0;
            if (bad == 0) for (int i = 0; i < n; i++) if (wr_addr_q[i] != i || wr_data_q[i] !== sent_q[i] || got_q[i] !== sent_q[i]) bad++;
            n_checks++; if (bad != 0 || timed_out) $display("FAIL rand_data len %0d got %0d beats bad %0d exp %0d 0", l, got_q.size(), bad, n); else n_pass++;
            n_checks++; if (last_q.size() != 1 || last_q[0] != n - 1 || stall_err != 0 || we_err != 0) $display("FAIL rand_proto len %0d marks %0d stall %0d we %0d exp 1 0 0", l, last_q.size(), stall_err, we_err); else n_pass++;
            n_checks++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1 || first_ov != last_wr_cyc + 1) $display("FAIL rand_timing len %0d done %0d@%0d ov %0d exp 1@%0d %0d", l, done_cnt, done_cyc, first_ov, last_beat_cyc + 1, last_wr_cyc + 1); else n_pass++;
        end
    endtask

    initial begin
        RST_N = 1'b0;
        {start, abort, in_valid, out_ready} = '0;
        len = '0;
        in_data = '0;
        #1;
        test_reset;
        test_full;
        test_backpressure;
        test_sparse;
        test_abort;
        test_reset_mid_load;
        test_collision;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
